// File: rtl/rx_pkg.sv
// Receive-side geometry and write-back beat shape for the OFM path.
package rx_pkg;

    localparam int RX_OFM_LANES = 64;
    localparam int RX_LANE_W    = 32;

    // Widest beat shape (one lane per beat needs a 6-bit index, 64 lanes need 2048 data bits).
    typedef struct packed {
        logic [RX_OFM_LANES*RX_LANE_W-1:0] data;
        logic [5:0]                        beat_idx;
        logic                              vec_end;
        logic                              last;
    } rx_wb_beat_port;

    function automatic logic lane_is_nan_inf(input logic [RX_LANE_W-1:0] lane);
        return lane[30:23] == 8'hFF;
    endfunction

endpackage

// File: rtl/tx_pkg.sv
// MAC-side transport types shared by the array and its receive path.
package tx_pkg;

    typedef struct packed {
        logic [2047:0] data;
        logic          is_last;
    } tx_mac_ofm_port;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mac_main_state;

endpackage

// File: rtl/mac_ofm_fifo.sv
// Whole-vector FIFO, registered count; head visible same cycle it is written-through to storage.
// Zero-latency pop of head; caller must not push when full_o or pop when empty_o.
module mac_ofm_fifo #(
    parameter int W     = 2049,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_dat_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/mac_ofm_rx.sv
// OFM receiver: buffers 64-lane vectors, emits BEATS write-back beats each; beat 0 one cycle after accept.
// Ready is !full of a registered count; beats hold while i_wb_ready is low. Option: MAC_OFM_RX_NAN_CHECK_EN.
module mac_ofm_rx
    import tx_pkg::*;
    import rx_pkg::*;
#(
    parameter  int OUT_LANES  = 8,
    parameter  int FIFO_DEPTH = 2,
    localparam int BEATS      = RX_OFM_LANES / OUT_LANES,
    localparam int BIDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int WB_W       = RX_LANE_W * OUT_LANES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ofm_valid,
    output logic                 o_ofm_ready,
    input  tx_mac_ofm_port       i_ofm,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [WB_W-1:0]      o_wb_data,
    output logic [BIDX_W-1:0]    o_wb_beat_idx,
    output logic                 o_wb_vec_end,
    output logic                 o_wb_last,
`ifdef MAC_OFM_RX_NAN_CHECK_EN
    output logic                 o_nan_inf,
    output logic                 o_wb_nan,
`endif
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int VEC_W = $bits(tx_mac_ofm_port);
`ifdef MAC_OFM_RX_NAN_CHECK_EN
    localparam int ENT_W = VEC_W + 1;
`else
    localparam int ENT_W = VEC_W;
`endif
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS-1);

    logic              push, pop, full, empty;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  push_ent, head_ent;
    tx_mac_ofm_port    head;

    mac_main_state     state_q, state_d;
    logic [BIDX_W-1:0] cnt_q, cnt_d;
    logic              wb_vld;

    // rst gates ready so nothing is accepted while the FIFO is being flushed.
    assign o_ofm_ready = !full && !rst;
    assign push        = i_ofm_valid && o_ofm_ready;

`ifdef MAC_OFM_RX_NAN_CHECK_EN
    logic [RX_OFM_LANES-1:0] lane_nan;
    logic                    in_nan, nan_q;

    for (genvar k = 0; k < RX_OFM_LANES; k++) begin : g_nan
        assign lane_nan[k] = lane_is_nan_inf(i_ofm.data[k*RX_LANE_W +: RX_LANE_W]);
    end
    assign in_nan   = |lane_nan;
    assign push_ent = {in_nan, i_ofm};
    assign head     = head_ent[VEC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            nan_q <= 1'b0;
        end else if (push && in_nan) begin
            nan_q <= 1'b1;
        end
    end

    assign o_nan_inf = nan_q;
    assign o_wb_nan  = wb_vld && head_ent[VEC_W];
`else
    assign push_ent = i_ofm;
    assign head     = head_ent;
`endif

    mac_ofm_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_ent),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RUN exactly tracks a non-empty FIFO, so beat 0 appears the cycle after the first push.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wb_vld  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (push) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wb_vld = 1'b1;
                if (i_wb_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        pop   = 1'b1;
                        cnt_d = '0;
                        if (count == CNT_W'(1) && !push) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + BIDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    logic [WB_W-1:0] beat_lanes [BEATS];
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign beat_lanes[b] = head.data[b*WB_W +: WB_W];
    end

    assign o_wb_valid    = wb_vld;
    assign o_wb_data     = wb_vld ? beat_lanes[cnt_q] : '0;
    assign o_wb_beat_idx = wb_vld ? cnt_q : '0;
    assign o_wb_vec_end  = wb_vld && (cnt_q == LAST_BEAT);
    assign o_wb_last     = o_wb_vec_end && head.is_last;
    assign o_busy        = !empty;

endmodule

// File: tb/tb_mac_ofm_rx.sv
// Directed bench for mac_ofm_rx at OUT_LANES=8, FIFO_DEPTH=2 (8 beats of 256 bits per vector).
module tb_mac_ofm_rx;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_ofm_valid;
    logic         o_ofm_ready;
    logic [2048:0] i_ofm;
    logic         o_wb_valid;
    logic         i_wb_ready;
    logic [255:0] o_wb_data;
    logic [2:0]   o_wb_beat_idx;
    logic         o_wb_vec_end;
    logic         o_wb_last;
    logic         o_busy;
`ifdef MAC_OFM_RX_NAN_CHECK_EN
    logic         o_nan_inf;
    logic         o_wb_nan;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mac_ofm_rx #(.OUT_LANES(8), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ofm_valid   (i_ofm_valid),
        .o_ofm_ready   (o_ofm_ready),
        .i_ofm         (i_ofm),
        .o_wb_valid    (o_wb_valid),
        .i_wb_ready    (i_wb_ready),
        .o_wb_data     (o_wb_data),
        .o_wb_beat_idx (o_wb_beat_idx),
        .o_wb_vec_end  (o_wb_vec_end),
        .o_wb_last     (o_wb_last),
`ifdef MAC_OFM_RX_NAN_CHECK_EN
        .o_nan_inf     (o_nan_inf),
        .o_wb_nan      (o_wb_nan),
`endif
        .o_busy        (o_busy)
    );

    // Lane k of a vector holds base+k; is_last sits in bit 0.
    function automatic logic [2048:0] mkvec(input logic [31:0] base, input logic is_last);
        logic [2047:0] d;
        for (int k = 0; k < 64; k++) d[32*k +: 32] = base + 32'(k);
        return {d, is_last};
    endfunction

    function automatic logic [255:0] expbeat(input logic [31:0] base, input int b);
        logic [255:0] r;
        for (int l = 0; l < 8; l++) r[32*l +: 32] = base + 32'(b*8 + l);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_ofm_valid = 1'b0; i_wb_ready = 1'b0; i_ofm = '0;
        step(); step();
        tests++;
        if ({o_ofm_ready, o_wb_valid, o_busy, o_wb_vec_end, o_wb_last} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctl got rdy/vld/busy/end/last=%b want 00000",
                     {o_ofm_ready, o_wb_valid, o_busy, o_wb_vec_end, o_wb_last});
        end
        tests++;
        if (o_wb_data !== '0 || o_wb_beat_idx !== 3'd0) begin
            fails++;
            $display("FAIL reset_dat got data=%h idx=%0d want 0/0", o_wb_data, o_wb_beat_idx);
        end
`ifdef MAC_OFM_RX_NAN_CHECK_EN
        tests++;
        if (o_nan_inf !== 1'b0) begin
            fails++; $display("FAIL reset_nan got %b want 0", o_nan_inf);
        end
`endif
        rst = 1'b0;
        #1;
        tests++;
        if (o_ofm_ready !== 1'b1) begin
            fails++; $display("FAIL reset_rdy_after got %b want 1", o_ofm_ready);
        end
        step();
    endtask

    task automatic test_single();
        i_wb_ready = 1'b1;
        i_ofm = mkvec(32'h1000_0000, 1'b1);
        i_ofm_valid = 1'b1;
        #1;
        tests++;
        if (o_wb_valid !== 1'b0) begin
            fails++; $display("FAIL single_pre_vld got %b want 0", o_wb_valid);
        end
        step();
        i_ofm_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            tests++;
            if ({o_wb_valid, o_wb_beat_idx, o_wb_vec_end, o_wb_last} !==
                {1'b1, 3'(b), b == 7, b == 7}) begin
                fails++;
                $display("FAIL single_ctl b=%0d got vld/idx/end/last=%b/%0d/%b/%b want 1/%0d/%b/%b",
                         b, o_wb_valid, o_wb_beat_idx, o_wb_vec_end, o_wb_last, b, b == 7, b == 7);
            end
            tests++;
            if (o_wb_data !== expbeat(32'h1000_0000, b)) begin
                fails++;
                $display("FAIL single_dat b=%0d got %h want %h", b, o_wb_data, expbeat(32'h1000_0000, b));
            end
            if (b == 3) begin
                tests++;
                if (o_wb_data[31:0] !== 32'h1000_0018 || o_wb_data[255:224] !== 32'h1000_001F) begin
                    fails++;
                    $display("FAIL single_b3_lanes got lo=%h hi=%h want 10000018/1000001f",
                             o_wb_data[31:0], o_wb_data[255:224]);
                end
            end
            step();
        end
        tests++;
        if (o_wb_valid !== 1'b0 || o_busy !== 1'b0) begin
            fails++; $display("FAIL single_done got vld=%b busy=%b want 0/0", o_wb_valid, o_busy);
        end
    endtask

    task automatic test_fill();
        int acc_at;
        logic acc;
        logic [31:0] base;
        i_wb_ready = 1'b0;
        i_ofm = mkvec(32'h2000_0000, 1'b0); i_ofm_valid = 1'b1;
        step();
        tests++;
        if (o_ofm_ready !== 1'b1) begin
            fails++; $display("FAIL fill_rdy1 got %b want 1", o_ofm_ready);
        end
        i_ofm = mkvec(32'h2100_0000, 1'b0);
        step();
        tests++;
        if (o_ofm_ready !== 1'b0) begin
            fails++; $display("FAIL fill_rdy2 got %b want 0", o_ofm_ready);
        end
        i_ofm = mkvec(32'h2200_0000, 1'b1);
        step(); step();
        tests++;
        if (o_ofm_ready !== 1'b0 || o_wb_beat_idx !== 3'd0 || o_wb_data !== expbeat(32'h2000_0000, 0)) begin
            fails++;
            $display("FAIL fill_hold got rdy=%b idx=%0d want 0/0", o_ofm_ready, o_wb_beat_idx);
        end
        i_wb_ready = 1'b1;
        acc_at = -1;
        for (int g = 0; g < 24; g++) begin
            base = 32'h2000_0000 + 32'(g / 8) * 32'h0100_0000;
            tests++;
            if ({o_wb_valid, o_wb_beat_idx, o_wb_vec_end, o_wb_last} !==
                {1'b1, 3'(g % 8), (g % 8) == 7, g == 23}) begin
                fails++;
                $display("FAIL fill_ctl g=%0d got vld/idx/end/last=%b/%0d/%b/%b", g,
                         o_wb_valid, o_wb_beat_idx, o_wb_vec_end, o_wb_last);
            end
            tests++;
            if (o_wb_data !== expbeat(base, g % 8)) begin
                fails++;
                $display("FAIL fill_dat g=%0d got %h want %h", g, o_wb_data, expbeat(base, g % 8));
            end
            acc = i_ofm_valid && o_ofm_ready;
            step();
            if (acc) begin
                i_ofm_valid = 1'b0;
                acc_at = g;
            end
        end
        tests++;
        if (acc_at !== 8) begin
            fails++; $display("FAIL fill_third_accept got beat %0d want 8", acc_at);
        end
        tests++;
        if (o_wb_valid !== 1'b0 || o_busy !== 1'b0) begin
            fails++; $display("FAIL fill_done got vld=%b busy=%b want 0/0", o_wb_valid, o_busy);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        logic stalled;
        logic [255:0] prev;
        i_wb_ready = 1'b0;
        i_ofm = mkvec(32'h3000_0000, 1'b1); i_ofm_valid = 1'b1;
        step();
        i_ofm_valid = 1'b0;
        hs = 0; stalled = 1'b0; prev = '0;
        for (int c = 0; c < 40 && hs < 8; c++) begin
            i_wb_ready = (c % 4 == 0) || (c % 4 == 3);
            tests++;
            if ({o_wb_valid, o_wb_beat_idx, o_wb_vec_end, o_wb_last} !==
                {1'b1, 3'(hs), hs == 7, hs == 7} || o_wb_data !== expbeat(32'h3000_0000, hs)) begin
                fails++;
                $display("FAIL bp_beat c=%0d got vld/idx=%b/%0d want 1/%0d", c, o_wb_valid, o_wb_beat_idx, hs);
            end
            if (stalled) begin
                tests++;
                if (o_wb_data !== prev) begin
                    fails++; $display("FAIL bp_hold c=%0d got %h want %h", c, o_wb_data, prev);
                end
            end
            stalled = !i_wb_ready;
            prev = o_wb_data;
            if (i_wb_ready) hs++;
            step();
        end
        tests++;
        if (hs !== 8 || o_wb_valid !== 1'b0) begin
            fails++; $display("FAIL bp_count got hs=%0d vld=%b want 8/0", hs, o_wb_valid);
        end
    endtask

    task automatic test_push_pop();
        i_wb_ready = 1'b1;
        i_ofm = mkvec(32'h4000_0000, 1'b0); i_ofm_valid = 1'b1;
        step();
        i_ofm_valid = 1'b0;
        for (int b = 0; b < 7; b++) step();
        tests++;
        if (o_wb_beat_idx !== 3'd7 || o_wb_vec_end !== 1'b1 || o_ofm_ready !== 1'b1) begin
            fails++;
            $display("FAIL pp_pre got idx=%0d end=%b rdy=%b want 7/1/1", o_wb_beat_idx, o_wb_vec_end, o_ofm_ready);
        end
        i_ofm = mkvec(32'h4100_0000, 1'b1); i_ofm_valid = 1'b1;
        step();
        i_ofm_valid = 1'b0;
        tests++;
        if (o_busy !== 1'b1 || o_ofm_ready !== 1'b1) begin
            fails++; $display("FAIL pp_count got busy=%b rdy=%b want 1/1", o_busy, o_ofm_ready);
        end
        for (int b = 0; b < 8; b++) begin
            tests++;
            if ({o_wb_valid, o_wb_beat_idx, o_wb_last} !== {1'b1, 3'(b), b == 7} ||
                o_wb_data !== expbeat(32'h4100_0000, b)) begin
                fails++;
                $display("FAIL pp_beat b=%0d got vld/idx/last=%b/%0d/%b", b, o_wb_valid, o_wb_beat_idx, o_wb_last);
            end
            step();
        end
        tests++;
        if (o_wb_valid !== 1'b0 || o_busy !== 1'b0) begin
            fails++; $display("FAIL pp_done got vld=%b busy=%b want 0/0", o_wb_valid, o_busy);
        end
    endtask

    task automatic test_reset_mid();
        i_wb_ready = 1'b1;
        i_ofm = mkvec(32'h5000_0000, 1'b0); i_ofm_valid = 1'b1;
        step();
        i_ofm = mkvec(32'h5100_0000, 1'b0);
        step();
        i_ofm_valid = 1'b0;
        step(); step(); step();
        tests++;
        if (o_wb_beat_idx !== 3'd4 || o_busy !== 1'b1) begin
            fails++; $display("FAIL rm_pre got idx=%0d busy=%b want 4/1", o_wb_beat_idx, o_busy);
        end
        rst = 1'b1;
        step();
        tests++;
        if ({o_wb_valid, o_busy, o_ofm_ready} !== 3'b000 || o_wb_beat_idx !== 3'd0) begin
            fails++;
            $display("FAIL rm_flush got vld/busy/rdy=%b idx=%0d want 000/0",
                     {o_wb_valid, o_busy, o_ofm_ready}, o_wb_beat_idx);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (o_ofm_ready !== 1'b1 || o_wb_valid !== 1'b0) begin
            fails++; $display("FAIL rm_after got rdy=%b vld=%b want 1/0", o_ofm_ready, o_wb_valid);
        end
        i_ofm = mkvec(32'h5200_0000, 1'b1); i_ofm_valid = 1'b1;
        step();
        i_ofm_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            tests++;
            if ({o_wb_valid, o_wb_beat_idx, o_wb_last} !== {1'b1, 3'(b), b == 7} ||
                o_wb_data !== expbeat(32'h5200_0000, b)) begin
                fails++;
                $display("FAIL rm_beat b=%0d got vld/idx/last=%b/%0d/%b", b, o_wb_valid, o_wb_beat_idx, o_wb_last);
            end
            step();
        end
        tests++;
        if (o_wb_valid !== 1'b0 || o_busy !== 1'b0) begin
            fails++; $display("FAIL rm_done got vld=%b busy=%b want 0/0", o_wb_valid, o_busy);
        end
    endtask

`ifdef MAC_OFM_RX_NAN_CHECK_EN
    task automatic test_nan();
        logic [2048:0] v;
        i_wb_ready = 1'b1;
        v = mkvec(32'h6000_0000, 1'b0);
        v[1 + 17*32 +: 32] = 32'h7FC0_0000;
        tests++;
        if (o_nan_inf !== 1'b0) begin
            fails++; $display("FAIL nan_pre got %b want 0", o_nan_inf);
        end
        i_ofm = v; i_ofm_valid = 1'b1;
        step();
        i_ofm = mkvec(32'h6100_0000, 1'b1);
        tests++;
        if (o_nan_inf !== 1'b1) begin
            fails++; $display("FAIL nan_set got %b want 1", o_nan_inf);
        end
        for (int g = 0; g < 16; g++) begin
            tests++;
            if (o_wb_valid !== 1'b1 || o_wb_nan !== (g < 8)) begin
                fails++; $display("FAIL nan_beat g=%0d got vld=%b nan=%b want 1/%b", g, o_wb_valid, o_wb_nan, g < 8);
            end
            step();
            i_ofm_valid = 1'b0;
        end
        tests++;
        if (o_nan_inf !== 1'b1 || o_wb_valid !== 1'b0) begin
            fails++; $display("FAIL nan_sticky got nan=%b vld=%b want 1/0", o_nan_inf, o_wb_valid);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
`ifdef MAC_OFM_RX_NAN_CHECK_EN
        test_nan();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
